imager_capture_sequencer: RTL and testbench

Parametrised multi-camera frame-capture scheduler for the imager subsystem. Sits between the APB register interface and NUM_CAMS stonyman controllers. Issues frame_capture_start to enabled cameras in ascending-index passes, once or continuously, and stalls a camera while its pixel FIFO is almost full. Supervises each capture with a timeout and keeps a frame counter and sticky error for software.

---
 rtl/imager_capture_sequencer_if.sv | 27 ++
 rtl/imager_capture_sequencer.sv | 159 +++++++++++++++
 tb/tb_imager_capture_sequencer.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/imager_capture_sequencer_if.sv
// Camera-side bundle of the imager capture sequencer: per-camera start and
// reset pulses towards the stonyman controllers, done pulses and FIFO
// almost-full flags back from them.
interface imager_capture_sequencer_if #(
    parameter int NUM_CAMS = 2
);
    logic [NUM_CAMS-1:0] cam_frame_capture_start;
    logic [NUM_CAMS-1:0] cam_reset;
    logic [NUM_CAMS-1:0] cam_frame_capture_done;
    logic [NUM_CAMS-1:0] cam_fifo_afull;

    // Sequencer side: issues start/reset, observes done/afull.
    modport master (
        output cam_frame_capture_start,
        output cam_reset,
        input  cam_frame_capture_done,
        input  cam_fifo_afull
    );

    // Camera side: receives start/reset, reports done/afull.
    modport slave (
        input  cam_frame_capture_start,
        input  cam_reset,
        output cam_frame_capture_done,
        output cam_fifo_afull
    );
endinterface

// File: rtl/imager_capture_sequencer.sv
// Multi-camera frame-capture scheduler. Serves enabled cameras in
// ascending-index passes (single or continuous), holds off a camera while its
// pixel FIFO is almost full, supervises each frame with a timeout and keeps a
// frame counter plus a sticky timeout error.
// Optional feature macro: IMAGER_SEQ_TIMESTAMP_EN adds a free-running 32-bit
// cycle counter and a frame_timestamp output latched at every frame start.
module imager_capture_sequencer #(
    parameter  int NUM_CAMS    = 2,
    parameter  int FRAME_CNT_W = 16,
    parameter  int TIMEOUT_W   = 24,
    localparam int CAM_IDX_W   = $clog2(NUM_CAMS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_CAMS-1:0]    cfg_cam_enable,
    input  logic                   cfg_continuous,
    input  logic [TIMEOUT_W-1:0]   cfg_timeout,
    input  logic                   seq_start,
    input  logic                   seq_stop,
    input  logic                   err_clear,
    imager_capture_sequencer_if.master cam,
    output logic                   seq_busy,
    output logic [CAM_IDX_W-1:0]   seq_active_cam,
    output logic [FRAME_CNT_W-1:0] frame_count,
    output logic                   irq_frame_done,
`ifdef IMAGER_SEQ_TIMESTAMP_EN
    output logic [31:0]            frame_timestamp,
`endif
    output logic                   err_timeout
);

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        WAIT_FIFO,
        START,
        CAPTURE,
        NEXT
    } state_t;

    state_t               state;
    logic [NUM_CAMS-1:0]  pass_remaining;
    logic                 stop_pending;
    logic [TIMEOUT_W-1:0] timer;
    logic [NUM_CAMS-1:0]  sel_onehot;
    logic                 stop_now;

    // Index of the lowest camera still owed a frame in this pass.
    function automatic logic [CAM_IDX_W-1:0] lowest_bit(input logic [NUM_CAMS-1:0] v);
        lowest_bit = '0;
        for (int i = NUM_CAMS - 1; i >= 0; i--) begin
            if (v[i]) lowest_bit = CAM_IDX_W'(i);
        end
    endfunction

    // One-hot decode of the camera currently being served.
    assign sel_onehot = {{(NUM_CAMS-1){1'b0}}, 1'b1} << seq_active_cam;
    assign stop_now   = stop_pending | seq_stop;
    assign seq_busy   = (state != IDLE);

    // Scheduler FSM with registered pulse outputs, counter and error flag.
    // NOTE: all state is updated with non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state                       <= IDLE;
            pass_remaining              <= '0;
            stop_pending                <= 1'b0;
            timer                       <= '0;
            seq_active_cam              <= '0;
            frame_count                 <= '0;
            irq_frame_done              <= 1'b0;
            err_timeout                 <= 1'b0;
            cam.cam_frame_capture_start <= '0;
            cam.cam_reset               <= '0;
        end else begin
            cam.cam_frame_capture_start <= '0;
            cam.cam_reset               <= '0;
            irq_frame_done              <= 1'b0;
            // A timeout set later in this block overrides the clear.
            if (err_clear) err_timeout <= 1'b0;

            case (state)
                IDLE: begin
                    if (seq_start && (cfg_cam_enable != '0)) begin
                        pass_remaining <= cfg_cam_enable;
                        stop_pending   <= 1'b0;
                        state          <= SELECT;
                    end
                end
                SELECT: begin
                    if (seq_stop) begin
                        state <= IDLE;
                    end else begin
                        seq_active_cam <= lowest_bit(pass_remaining);
                        state          <= WAIT_FIFO;
                    end
                end
                WAIT_FIFO: begin
                    if (seq_stop) begin
                        state <= IDLE;
                    end else if (!cam.cam_fifo_afull[seq_active_cam]) begin
                        cam.cam_frame_capture_start <= sel_onehot;
                        timer                       <= '0;
                        state                       <= START;
                    end
                end
                START: begin
                    if (seq_stop) stop_pending <= 1'b1;
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    timer <= timer + 1'b1;
                    if (seq_stop) stop_pending <= 1'b1;
                    if (cam.cam_frame_capture_done[seq_active_cam]) begin
                        irq_frame_done <= 1'b1;
                        frame_count    <= frame_count + 1'b1;
                        pass_remaining <= pass_remaining & ~sel_onehot;
                        state          <= NEXT;
                    end else if ((cfg_timeout != '0) &&
                                 (timer == cfg_timeout - TIMEOUT_W'(1))) begin
                        err_timeout    <= 1'b1;
                        cam.cam_reset  <= sel_onehot;
                        pass_remaining <= pass_remaining & ~sel_onehot;
                        state          <= NEXT;
                    end
                end
                NEXT: begin
                    if ((pass_remaining != '0) && !stop_now) begin
                        state <= SELECT;
                    end else if ((pass_remaining == '0) && cfg_continuous && !stop_now &&
                                 (cfg_cam_enable != '0)) begin
                        pass_remaining <= cfg_cam_enable;
                        state          <= SELECT;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef IMAGER_SEQ_TIMESTAMP_EN
    logic [31:0] cycle_count;

    // Free-running cycle counter; its value is captured at each frame start.
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_count     <= '0;
            frame_timestamp <= '0;
        end else begin
            cycle_count <= cycle_count + 1'b1;
            if (state == START) frame_timestamp <= cycle_count;
        end
    end
`endif

endmodule

// File: tb/tb_imager_capture_sequencer.sv
// Self-checking bench for imager_capture_sequencer (NUM_CAMS = 2). Expected
// start/reset/irq events are queued by the stimulus and popped by a monitor
// when the DUT emits the corresponding pulse.
module tb_imager_capture_sequencer;

    localparam int NUM_CAMS = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  cfg_cam_enable;
    logic        cfg_continuous;
    logic [23:0] cfg_timeout;
    logic        seq_start, seq_stop, err_clear;
    logic        seq_busy;
    logic [0:0]  seq_active_cam;
    logic [15:0] frame_count;
    logic        irq_frame_done;
    logic        err_timeout;
`ifdef IMAGER_SEQ_TIMESTAMP_EN
    logic [31:0] frame_timestamp;
`endif

    imager_capture_sequencer_if #(.NUM_CAMS(NUM_CAMS)) cam_if ();

    imager_capture_sequencer #(.NUM_CAMS(NUM_CAMS)) dut (
        .clk            (clk),
        .reset          (reset),
        .cfg_cam_enable (cfg_cam_enable),
        .cfg_continuous (cfg_continuous),
        .cfg_timeout    (cfg_timeout),
        .seq_start      (seq_start),
        .seq_stop       (seq_stop),
        .err_clear      (err_clear),
        .cam            (cam_if),
        .seq_busy       (seq_busy),
        .seq_active_cam (seq_active_cam),
        .frame_count    (frame_count),
        .irq_frame_done (irq_frame_done),
`ifdef IMAGER_SEQ_TIMESTAMP_EN
        .frame_timestamp(frame_timestamp),
`endif
        .err_timeout    (err_timeout)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int start_count = 0;
    int start_cyc   = 0;
    int rst_cyc     = 0;
    int done_delay  = 0;

    logic [1:0]  exp_start[$];
    logic [1:0]  exp_rst[$];
    logic [15:0] exp_irq[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every pulse must match the head of its expectation queue.
    always @(negedge clk) begin
        if (!reset) begin
            if (cam_if.cam_frame_capture_start != 2'b00) begin
                start_count = start_count + 1;
                start_cyc   = cyc;
                if (exp_start.size() == 0)
                    check("start_unexpected", 32'(cam_if.cam_frame_capture_start), 0);
                else
                    check("start", 32'(cam_if.cam_frame_capture_start), 32'(exp_start.pop_front()));
                check("active_cam", 32'(seq_active_cam), 32'(cam_if.cam_frame_capture_start[1]));
            end
            if (cam_if.cam_reset != 2'b00) begin
                rst_cyc = cyc;
                if (exp_rst.size() == 0)
                    check("cam_reset_unexpected", 32'(cam_if.cam_reset), 0);
                else
                    check("cam_reset", 32'(cam_if.cam_reset), 32'(exp_rst.pop_front()));
            end
            if (irq_frame_done) begin
                if (exp_irq.size() == 0)
                    check("irq_unexpected", 32'(frame_count), 32'hFFFF_FFFF);
                else
                    check("irq_frame_count", 32'(frame_count), 32'(exp_irq.pop_front()));
            end
        end
    end

    // Camera model: answers a start pulse with a done pulse in the
    // done_delay-th CAPTURE cycle (0 = never answers).
    initial begin
        cam_if.cam_frame_capture_done = 2'b00;
        forever begin
            @(negedge clk);
            if (cam_if.cam_frame_capture_start != 2'b00 && done_delay > 0) begin
                logic [1:0] who;
                who = cam_if.cam_frame_capture_start;
                repeat (done_delay) @(negedge clk);
                cam_if.cam_frame_capture_done = who;
                @(negedge clk);
                cam_if.cam_frame_capture_done = 2'b00;
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk) seq_start = 1'b1;
        @(negedge clk) seq_start = 1'b0;
    endtask

    task automatic pulse_stop();
        @(negedge clk) seq_stop = 1'b1;
        @(negedge clk) seq_stop = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        @(negedge clk);
        while (seq_busy && n < max) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", 32'(seq_busy), 0);
    endtask

    task automatic wait_starts(input int target, input int max);
        int n = 0;
        while (start_count < target && n < max) begin
            @(posedge clk);
            n++;
        end
        check("start_seen", 32'(start_count >= target), 1);
    endtask

    task automatic check_queues(input string tag);
        check({tag, "_q_start"}, 32'(exp_start.size()), 0);
        check({tag, "_q_rst"},   32'(exp_rst.size()), 0);
        check({tag, "_q_irq"},   32'(exp_irq.size()), 0);
    endtask

    initial begin
        int base;
        reset = 1'b1;
        cfg_cam_enable = 2'b00; cfg_continuous = 1'b0; cfg_timeout = '0;
        seq_start = 1'b0; seq_stop = 1'b0; err_clear = 1'b0;
        cam_if.cam_fifo_afull = 2'b00;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state.
        @(negedge clk);
        check("rst_start", 32'(cam_if.cam_frame_capture_start), 0);
        check("rst_cam_reset", 32'(cam_if.cam_reset), 0);
        check("rst_busy", 32'(seq_busy), 0);
        check("rst_count", 32'(frame_count), 0);
        check("rst_err", 32'(err_timeout), 0);

        // Single pass over both cameras, done 10 cycles after each start.
        done_delay = 10; cfg_cam_enable = 2'b11;
        exp_start.push_back(2'b01); exp_start.push_back(2'b10);
        exp_irq.push_back(16'd1);   exp_irq.push_back(16'd2);
        pulse_start();
        wait_idle(200);
        check("t1_count", 32'(frame_count), 2);
        check_queues("t1");

        // FIFO almost-full holds off the start.
        cfg_cam_enable = 2'b10; cam_if.cam_fifo_afull = 2'b10;
        exp_start.push_back(2'b10); exp_irq.push_back(16'd3);
        base = start_count;
        pulse_start();
        repeat (20) @(negedge clk);
        check("t2_held", 32'(start_count - base), 0);
        check("t2_busy", 32'(seq_busy), 1);
        cam_if.cam_fifo_afull = 2'b00;
        wait_idle(200);
        check("t2_one_start", 32'(start_count - base), 1);
        check_queues("t2");

        // Timeout on cam0: reset pulse after cfg_timeout CAPTURE cycles.
        done_delay = 0; cfg_timeout = 24'd50; cfg_cam_enable = 2'b01;
        exp_start.push_back(2'b01); exp_rst.push_back(2'b01);
        pulse_start();
        wait_idle(300);
        check("t3_err", 32'(err_timeout), 1);
        check("t3_count", 32'(frame_count), 3);
        check("t3_latency", 32'(rst_cyc - start_cyc), 51);
        check_queues("t3");
        @(negedge clk) err_clear = 1'b1;
        @(negedge clk) err_clear = 1'b0;
        check("t3_err_clear", 32'(err_timeout), 0);

        // Continuous mode stopped during cam1 capture.
        cfg_timeout = '0; done_delay = 10; cfg_continuous = 1'b1; cfg_cam_enable = 2'b11;
        exp_start.push_back(2'b01); exp_start.push_back(2'b10);
        exp_irq.push_back(16'd4);   exp_irq.push_back(16'd5);
        base = start_count;
        pulse_start();
        wait_starts(base + 2, 200);
        repeat (3) @(posedge clk);
        pulse_stop();
        wait_idle(200);
        check("t4_count", 32'(frame_count), 5);
        repeat (20) @(negedge clk);
        check("t4_no_more", 32'(start_count - base), 2);
        check_queues("t4");

        // Done coincides with timeout expiry: done wins.
        cfg_continuous = 1'b0; cfg_timeout = 24'd20; done_delay = 20; cfg_cam_enable = 2'b01;
        exp_start.push_back(2'b01); exp_irq.push_back(16'd6);
        pulse_start();
        wait_idle(200);
        check("t5_err", 32'(err_timeout), 0);
        check("t5_count", 32'(frame_count), 6);
        check_queues("t5");

        // Mask change mid-pass only applies at the next reload.
        cfg_timeout = '0; done_delay = 10; cfg_continuous = 1'b1; cfg_cam_enable = 2'b11;
        exp_start.push_back(2'b01); exp_start.push_back(2'b10); exp_start.push_back(2'b01);
        exp_irq.push_back(16'd7); exp_irq.push_back(16'd8); exp_irq.push_back(16'd9);
        base = start_count;
        pulse_start();
        wait_starts(base + 1, 100);
        @(negedge clk) cfg_cam_enable = 2'b01;
        wait_starts(base + 3, 200);
        repeat (3) @(posedge clk);
        pulse_stop();
        wait_idle(200);
        check("t6_count", 32'(frame_count), 9);
        check_queues("t6");

        // Reset in CAPTURE returns everything to reset values.
        cfg_continuous = 1'b0; done_delay = 0; cfg_cam_enable = 2'b01;
        exp_start.push_back(2'b01);
        base = start_count;
        pulse_start();
        wait_starts(base + 1, 100);
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        @(negedge clk);
        check("t7_busy", 32'(seq_busy), 0);
        check("t7_count", 32'(frame_count), 0);
        check("t7_start", 32'(cam_if.cam_frame_capture_start), 0);
        check("t7_cam_reset", 32'(cam_if.cam_reset), 0);
        check("t7_irq", 32'(irq_frame_done), 0);
        check("t7_active", 32'(seq_active_cam), 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("t7_stay_idle", 32'(seq_busy), 0);
        check_queues("t7");

        // seq_start with an all-zero mask is ignored.
        cfg_cam_enable = 2'b00;
        base = start_count;
        pulse_start();
        repeat (3) @(negedge clk);
        check("t8_busy", 32'(seq_busy), 0);
        check("t8_no_start", 32'(start_count - base), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
